// File: rtl/mem_burst_ctrl_pkg.sv
// rtl/mem_burst_ctrl_pkg.sv - shared constants, FSM state type and address wrap helper
package mem_burst_ctrl_pkg;

    localparam int DEPTH   = 528;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Next bank address; the bank is not a power of two deep, so wrap explicitly.
    function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(DEPTH - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// rtl/mem_rd_fifo.sv - 2-entry synchronous FIFO holding read beats and their last flag
module mem_rd_fifo #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Storage and pointers; the caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - arbitrates single writes and read bursts onto one bank port
module mem_burst_ctrl
    import mem_burst_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic              rd_cmd_valid,
    output logic              rd_cmd_ready,
    input  logic [ADDR_W-1:0] rd_cmd_addr,
    input  logic [LEN_W-1:0]  rd_cmd_len,
    output logic              rd_data_valid,
    input  logic              rd_data_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_last,
    output logic              busy,
    output logic              mem_chip_en,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              prev_rd_q;

    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic              fifo_pop;
    logic [2:0]        occ;
    logic              rd_eligible;
    logic              wr_fire;
    logic              rd_issue;
    logic              cmd_fire;

    // Read beats land here one cycle after issue; the MSB carries the last flag.
    mem_rd_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .pop_i   (fifo_pop),
        .data_i  ({inflight_last_q, mem_rd_data}),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    // Handshakes and bank drive; everything is held off while reset is asserted.
    always_comb begin
        rd_data_valid = rst_n && (fifo_count != 2'd0);
        rd_data       = rd_data_valid ? fifo_head[DATA_W-1:0] : '0;
        rd_data_last  = rd_data_valid & fifo_head[DATA_W];
        fifo_pop      = rd_data_valid & rd_data_ready;
        // Count the beat already in flight so a third beat is never issued.
        occ           = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
        rd_eligible   = rst_n && (state_q == BURST) && (occ < 3'd2);

        wr_req_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:    wr_req_ready = 1'b1;
                BURST:   wr_req_ready = prev_rd_q | ~rd_eligible;
                DRAIN:   wr_req_ready = 1'b1;
                default: wr_req_ready = 1'b0;
            endcase
        end
        rd_cmd_ready = rst_n && (state_q == IDLE) && !wr_req_valid;

        wr_fire  = wr_req_valid & wr_req_ready;
        rd_issue = rd_eligible & ~wr_fire;
        cmd_fire = rd_cmd_valid & rd_cmd_ready;

        mem_wr_en   = wr_fire;
        mem_rd_en   = rd_issue;
        mem_chip_en = wr_fire | rd_issue;
        mem_wr_addr = wr_fire ? wr_req_addr : '0;
        mem_wr_data = wr_fire ? wr_req_data : '0;
        mem_rd_addr = rd_issue ? addr_q : '0;
    end

    // Burst sequencing: latch command, walk addresses, wait for the final beat to leave.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            prev_rd_q       <= 1'b0;
        end else begin
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (remain_q == LEN_W'(1));
            prev_rd_q       <= rd_issue;
            case (state_q)
                IDLE: begin
                    if (cmd_fire && (rd_cmd_len != '0)) begin
                        addr_q   <= rd_cmd_addr;
                        remain_q <= rd_cmd_len;
                        state_q  <= BURST;
                    end
                end
                BURST: begin
                    if (rd_issue) begin
                        addr_q   <= addr_wrap_inc(addr_q);
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_pop && fifo_head[DATA_W]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    // Protocol invariants and caller-error checks.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_wr_en && mem_rd_en));
            assert (!(mem_wr_en || mem_rd_en) || mem_chip_en);
            assert (!(inflight_q && (fifo_count == 2'd2) && !fifo_pop));
            assert (!wr_fire || (32'(wr_req_addr) < DEPTH));
            assert (!cmd_fire || ((32'(rd_cmd_addr) < DEPTH) && (32'(rd_cmd_len) <= MAX_LEN)));
        end
    end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Initiator side of the single-port memory bank interface.
- Accepts single-word write requests and multi-word read-burst commands, and arbitrates them onto one bank port.
- Absorbs the bank's fixed 1-cycle read latency and streams read data out through a valid/ready port with backpressure.
- Sits between compute/DMA clients and one bank instance; guarantees the bank never sees simultaneous read and write, or access with chip enable low.

Parameters:
DEPTH, 528, bank word count
DATA_W, 16, word width (fixed-point)
ADDR_W, $clog2(DEPTH), address width
MAX_LEN, 64, max burst length; LEN_W = $clog2(MAX_LEN+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_req_valid  in  1  write request present
wr_req_ready  out  1  write accepted this cycle when valid&ready
wr_req_addr  in  ADDR_W  write address
wr_req_data  in  DATA_W  write data
rd_cmd_valid  in  1  burst command present
rd_cmd_ready  out  1  burst command accepted when valid&ready
rd_cmd_addr  in  ADDR_W  burst start address
rd_cmd_len  in  LEN_W  beats, 0..MAX_LEN
rd_data_valid  out  1  output beat valid
rd_data_ready  in  1  consumer ready
rd_data  out  DATA_W  output beat
rd_data_last  out  1  final beat of burst
busy  out  1  FSM not IDLE
mem_chip_en  out  1  bank chip enable
mem_wr_en  out  1  bank write enable
mem_rd_en  out  1  bank read enable
mem_wr_addr  out  ADDR_W  bank write address
mem_rd_addr  out  ADDR_W  bank read address
mem_wr_data  out  DATA_W  bank write data
mem_rd_data  in  DATA_W  bank read data, valid the cycle after mem_rd_en

Behaviour:
- Reset: synchronous, active-low, on clk. All outputs 0, FSM IDLE, FIFO empty, in-flight flag cleared.
- Reset mid-burst aborts the burst; no further beats are produced.
- Bank drive:
  - mem_chip_en = mem_wr_en | mem_rd_en.
  - mem_wr_en and mem_rd_en are never both 1.
  - mem_* outputs are combinational from state and the accepted request; the write handshake is a same-cycle bank write.
- In-flight flag: set the cycle after mem_rd_en. Capture mem_rd_data into the FIFO only when the flag is set, never otherwise.
- Output FIFO: 2 entries.
  - occ = fifo_count + inflight − pop, where pop = rd_data_valid & rd_data_ready.
  - Read issue requires occ < 2. This sustains 1 beat/cycle when rd_data_ready is held high.
- FSM IDLE:
  - Write has priority: wr_req_ready = 1.
  - rd_cmd_ready = ~wr_req_valid.
  - On a command with len>0: latch addr and remaining=len, go to BURST.
  - On len=0: accept, no reads, no beats, stay IDLE.
- FSM BURST:
  - Issue one read per eligible cycle; mem_rd_addr = current address.
  - Address increments and wraps DEPTH−1 → 0.
  - remaining decrements per issue.
  - Writes interleave round-robin: wr_req_ready = 1 when the previous bank cycle was a read or no read is eligible this cycle.
  - rd_cmd_ready = 0.
  - After the last issue go to DRAIN.
- FSM DRAIN:
  - Writes accepted every cycle.
  - Go to IDLE on the cycle the final beat handshakes (last & valid & ready).
- rd_data_last: 1 exactly on the beat numbered len of the burst.
- rd_data, rd_data_valid and rd_data_last hold stable while valid & ~ready.
- Latency: command accepted at cycle t → first mem_rd_en at t+1 → rd_data_valid at t+3 (data captured into the FIFO at t+2, registered out).
- busy = (state != IDLE).
- Simultaneous cmd and write in IDLE: write wins; command waits.
- Out-of-range addresses (≥ DEPTH) are a caller error; checked by assertion only.

Decomposition:
- Shared package: DATA_W, the fsm state enum (IDLE, BURST, DRAIN), and the address-wrap increment function.
- One sub-module: mem_rd_fifo, a 2-entry synchronous FIFO with push/pop/count, sized by DATA_W + 1 (data + last).
- Assertions live in the top: no simultaneous wr/rd, no enable without chip enable, no FIFO overflow.

Test Plan:
- Write addr 5 = 0x1234, then burst addr 5 len 1, ready=1 → single beat 0x1234, last=1, first mem_rd_en 1 cycle after cmd, valid 3 cycles after cmd.
- Preload 0..7 with value=addr; burst addr 0 len 8, ready=1 → 8 beats 0..7 on consecutive cycles, last only on beat 8, busy falls the cycle after.
- Same burst with ready toggling 1,0,0,1,... → no beat lost or duplicated; data stable during stalls; FIFO never overflows (assert silent).
- Burst addr DEPTH−2 len 4 → reads DEPTH−2, DEPTH−1, 0, 1 in order.
- wr_req_valid held high during a len-16 burst → bank sees alternating rd/wr; never both enables; all writes land; burst data correct.
- rst_n low for 1 cycle mid-burst (after beat 3 of 8) → all outputs 0 next cycle, no further beats; new burst afterwards behaves normally. Also: len=0 command → accepted, no mem_rd_en, no beats.
